// File: rtl/shift_add_multiplier_8b.sv
// Sequential unsigned shift-and-add multiplier that sequences operands into an external WIDTH-bit adder.
// Optional MUL_ZERO_SKIP_EN: a start with a zero operand goes straight to DONE with P=0.
module shift_add_multiplier_8b #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_s,
    input  logic               add_cout
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     m_q;
    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     q_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   p_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic                 zero_op;

    // Adder carry becomes the new accumulator MSB as the pair shifts right.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == BUSY) begin
            add_a = acc_q;
            add_b = q_q[0] ? m_q : '0;
        end
        acc_d = {add_cout, add_s, q_q[WIDTH-1:1]};
    end

`ifdef MUL_ZERO_SKIP_EN
    assign zero_op = (A == '0) || (B == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (zero_op) begin
                            p_q     <= '0;
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            m_q     <= A;
                            q_q     <= B;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= BUSY;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    {acc_q, q_q} <= acc_d;
                    cnt_q        <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        p_q     <= acc_d;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign P    = p_q;
endmodule

// File: tb/tb_shift_add_multiplier_8b.sv
// Bench for shift_add_multiplier_8b: behavioural ripple adder on the add_* ports, cycle model, directed vectors.
module tb_shift_add_multiplier_8b;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic           busy, done, add_cin, add_cout;
    logic [2*W-1:0] P;
    logic [W-1:0]   add_a, add_b, add_s;

    int checks = 0;
    int errors = 0;

    shift_add_multiplier_8b #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .P(P),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout)
    );

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    always #5 clk = ~clk;

    // Model: cycles remaining in the current transaction (busy while >=2, done when 1) and expected product.
    int             rem = 0;
    logic [2*W-1:0] prod_exp = '0;
    logic [2*W-1:0] p_exp = '0;
    bit             chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            rem   = 0;
            p_exp = '0;
        end else if (rem == 0) begin
            if (start) begin
                prod_exp = {{W{1'b0}}, A} * {{W{1'b0}}, B};
`ifdef MUL_ZERO_SKIP_EN
                if (A == 0 || B == 0) begin
                    rem   = 1;
                    p_exp = '0;
                end else rem = W + 1;
`else
                rem = W + 1;
`endif
            end
        end else begin
            rem = rem - 1;
            if (rem == 1) p_exp = prod_exp;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(rem >= 2));
            check("done", 32'(done), 32'(rem == 1));
            check("cin", 32'(add_cin), 32'd0);
            if (rem == 1 || rem == 0) check("P", 32'(P), 32'(p_exp));
            if (rem < 2) check("add_ab_idle", {add_a, add_b}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        @(negedge clk);
        while (!done && n < limit) begin
            n++;
            @(negedge clk);
        end
        if (!done) check("done_timeout", 32'(n), 32'(limit + 1));
    endtask

    task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp, input string name);
        int n;
        A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20, n);
        check({name, "_lat"}, 32'(n), 32'(W));
        check(name, 32'(P), 32'(exp));
        check({name, "_model"}, 32'(p_exp), 32'(exp));
        tick();
    endtask

    initial begin
        int n;
        // 1: reset
        rst = 1'b1;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_P", 32'(P), 32'd0);
        check("rst_add", {add_a, add_b}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // 2/3: basic and carry-path products
        mul(8'd3, 8'd5, 16'd15, "p3x5");
        repeat (3) tick();
        check("p_held", 32'(P), 32'd15);
        mul(8'hFF, 8'hFF, 16'hFE01, "pFFxFF");
        mul(8'h81, 8'h81, 16'h4101, "p81x81");
        mul(8'hFF, 8'h01, 16'h00FF, "pFFx01");

        // 4: start held high, operands changed mid-run
        A = 8'd3; B = 8'd5; start = 1'b1;
        tick();
        A = 8'd7; B = 8'd9;
        wait_done(20, n);
        check("hold_first", 32'(P), 32'd15);
        tick();
        @(negedge clk);
        check("hold_idle_gap", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        wait_done(20, n);
        check("hold_second", 32'(P), 32'd63);
        tick();

        // 5: reset in the 4th busy cycle
        A = 8'd9; B = 8'd9; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_P", 32'(P), 32'd0);
        repeat (12) tick();
        check("abort_no_done_P", 32'(P), 32'd0);
        mul(8'd2, 8'd3, 16'd6, "p2x3");

        // 6: zero operand
        A = 8'd0; B = 8'h37; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20, n);
`ifdef MUL_ZERO_SKIP_EN
        check("zero_lat", 32'(n), 32'd0);
`else
        check("zero_lat", 32'(n), 32'(W));
`endif
        check("zero_P", 32'(P), 32'd0);
        tick();
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
